// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID-stage hazard signals between the pipeline (master) and hazard_ctrl (slave)
//  master drives the ID operand/destination info, branch resolution and memory wait;
//  slave returns stall/flush controls, forwarding selects and the stall-cycle counter.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic             id_valid;
  logic [4:0]       rR1;
  logic [4:0]       rR2;
  logic             rs1_used;
  logic             rs2_used;
  logic [4:0]       id_wR;
  logic             id_rf_we;
  logic             id_is_load;
  logic             br_taken_ex;
  logic             ext_stall;
  logic             stall_pc;
  logic             stall_ifid;
  logic             flush_ifid;
  logic             flush_idex;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output id_valid, rR1, rR2, rs1_used, rs2_used, id_wR, id_rf_we, id_is_load, br_taken_ex, ext_stall,
    input  stall_pc, stall_ifid, flush_ifid, flush_idex, fwd_a, fwd_b, stall_cnt
  );
  modport slave (
    input  id_valid, rR1, rR2, rs1_used, rs2_used, id_wR, id_rf_we, id_is_load, br_taken_ex, ext_stall,
    output stall_pc, stall_ifid, flush_ifid, flush_idex, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage RV32I hazard unit - EX/MEM/WB destination tracker, forwarding, load-use stall, branch flush
//  clk, rst (sync, active-high)
//  h.*  : ID inputs (id_valid, rR1/rR2, rs1_used/rs2_used, id_wR, id_rf_we, id_is_load), br_taken_ex, ext_stall
//         outputs stall_pc, stall_ifid, flush_ifid, flush_idex, fwd_a/fwd_b (0 RF,1 EX,2 MEM,3 WB), stall_cnt
module hazard_ctrl #(parameter int CNT_W = 32) (
  input  logic   clk,
  input  logic   rst,
  hazard_ctrl_if.slave h
);
  typedef struct packed {
    logic       v;
    logic [4:0] wr;
    logic       we;
    logic       ld;
  } slot_t;
  slot_t            ex, mem, wb;
  logic [CNT_W-1:0] cnt;
  logic             load_use, bubble;
  function automatic logic hit(slot_t s, logic [4:0] r);
    return s.v & s.we & (s.wr == r) & (r != 5'd0);
  endfunction
  // youngest producer wins, so EX is checked before MEM before WB
  function automatic logic [1:0] sel(slot_t e, slot_t m, slot_t w, logic used, logic [4:0] r);
    return !used ? 2'd0 : hit(e, r) ? 2'd1 : hit(m, r) ? 2'd2 : hit(w, r) ? 2'd3 : 2'd0;
  endfunction
  always_comb begin
    load_use     = ~rst & h.id_valid & ex.ld & ((h.rs1_used & hit(ex, h.rR1)) | (h.rs2_used & hit(ex, h.rR2)));
    bubble       = load_use | h.br_taken_ex;
    // a taken branch discards the ID instruction, so its load-use stall is moot
    h.stall_pc   = ~rst & (h.ext_stall | (load_use & ~h.br_taken_ex));
    h.stall_ifid = h.stall_pc;
    h.flush_ifid = ~rst & ~h.ext_stall & h.br_taken_ex;
    h.flush_idex = ~rst & ~h.ext_stall & bubble;
    h.fwd_a      = (rst | load_use) ? 2'd0 : sel(ex, mem, wb, h.rs1_used, h.rR1);
    h.fwd_b      = (rst | load_use) ? 2'd0 : sel(ex, mem, wb, h.rs2_used, h.rR2);
  end
  assign h.stall_cnt = cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
      cnt <= '0;
    end else begin
      if (!h.ext_stall) begin
        wb  <= mem;
        mem <= ex;
        ex  <= '{v: h.id_valid & ~bubble, wr: h.id_wR, we: h.id_rf_we, ld: h.id_is_load};
      end
      if (h.stall_pc && !(&cnt)) cnt <= cnt + 1'b1;
    end
  end
endmodule
